// File: rtl/conv_seq_pkg.sv
// Shared types for the convolution sequencer: FSM state encoding and the
// address/index width helper used by conv_seq_ctrl and conv_win_addr_gen.
package conv_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        DRAIN,
        OUT,
        DONE
    } state_t;

    // Bits needed to index n items, never narrower than one bit.
    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_win_addr_gen.sv
// Window/tap counters for the convolution walk: owns r, c, kr, kc and turns
// them into pixel/weight read addresses plus the raster index of the window.
module conv_win_addr_gen
    import conv_seq_pkg::*;
#(
    parameter int IFMAP  = 5,
    parameter int FILTER = 3,
    parameter int AW     = cw(IFMAP * IFMAP),
    parameter int KW     = cw(FILTER * FILTER),
    parameter int OW     = cw((IFMAP - FILTER + 1) * (IFMAP - FILTER + 1))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step_tap,
    input  logic          step_win,
    input  logic          clear,
    output logic [AW-1:0] img_rd_addr,
    output logic [KW-1:0] flt_rd_addr,
    output logic [OW-1:0] win_idx,
    output logic          first_tap,
    output logic          last_tap,
    output logic          last_win
);

    localparam int OSZ = IFMAP - FILTER + 1;
    localparam int KCW = cw(FILTER);
    localparam int RCW = cw(OSZ);
    localparam logic [KCW-1:0] KMAX = KCW'(FILTER - 1);
    localparam logic [RCW-1:0] RMAX = RCW'(OSZ - 1);

    logic [KCW-1:0] kr, kc;
    logic [RCW-1:0] r, c;

    // Taps walk kc fastest then kr; windows walk c fastest then r.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r  <= '0;
            c  <= '0;
            kr <= '0;
            kc <= '0;
        end else if (clear) begin
            r  <= '0;
            c  <= '0;
            kr <= '0;
            kc <= '0;
        end else begin
            if (step_tap) begin
                if (kc == KMAX) begin
                    kc <= '0;
                    kr <= (kr == KMAX) ? '0 : kr + 1'b1;
                end else begin
                    kc <= kc + 1'b1;
                end
            end
            if (step_win) begin
                if (c == RMAX) begin
                    c <= '0;
                    r <= (r == RMAX) ? '0 : r + 1'b1;
                end else begin
                    c <= c + 1'b1;
                end
            end
        end
    end

    assign first_tap   = (kr == '0) && (kc == '0);
    assign last_tap    = (kr == KMAX) && (kc == KMAX);
    assign last_win    = (r == RMAX) && (c == RMAX);
    assign img_rd_addr = AW'((int'(r) + int'(kr)) * IFMAP + int'(c) + int'(kc));
    assign flt_rd_addr = KW'(int'(kr) * FILTER + int'(kc));
    assign win_idx     = OW'(int'(r) * OSZ + int'(c));

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for the serial-input 2-D convolution datapath: load, per-window
// tap walk, drain, handshaked output. Define CONV_SEQ_PERF_EN for perf counters.
module conv_seq_ctrl
    import conv_seq_pkg::*;
#(
    parameter int IFMAP   = 5,
    parameter int FILTER  = 3,
    parameter int MAC_LAT = 1,
    parameter int AW      = cw(IFMAP * IFMAP),
    parameter int KW      = cw(FILTER * FILTER),
    parameter int OW      = cw((IFMAP - FILTER + 1) * (IFMAP - FILTER + 1))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          img_wr_en,
    output logic [AW-1:0] img_wr_addr,
    output logic          flt_wr_en,
    output logic [KW-1:0] flt_wr_addr,
    output logic [AW-1:0] img_rd_addr,
    output logic [KW-1:0] flt_rd_addr,
    output logic          mac_en,
    output logic          mac_clear,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_idx,
    output logic          out_last,
    output logic          busy,
    output logic          done
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [31:0]   perf_cycles,
    output logic [15:0]   perf_stall
`endif
);

    localparam int DW = cw(MAC_LAT);
    localparam logic [AW-1:0] LAST_BEAT  = AW'(IFMAP * IFMAP - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(MAC_LAT - 1);

    state_t        state;
    logic [AW-1:0] load_cnt;
    logic [DW-1:0] drain_cnt;
    logic          beat, out_fire, step_win, addr_clear;
    logic          first_tap, last_tap, last_win;
    logic [OW-1:0] win_idx;

    assign beat        = in_valid && in_ready;
    assign img_wr_en   = beat;
    assign img_wr_addr = load_cnt;
    assign flt_wr_en   = beat && (int'(load_cnt) < FILTER * FILTER);
    assign flt_wr_addr = load_cnt[KW-1:0];
    assign mac_clear   = mac_en && first_tap;
    assign out_fire    = out_valid && out_ready;
    assign out_last    = out_valid && last_win;
    assign out_idx     = win_idx;
    assign step_win    = out_fire && !last_win;
    // Counters restart on a new job and after the final window is taken.
    assign addr_clear  = ((state == IDLE) && start) || (out_fire && last_win);

    conv_win_addr_gen #(
        .IFMAP (IFMAP),
        .FILTER(FILTER),
        .AW    (AW),
        .KW    (KW),
        .OW    (OW)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .step_tap   (mac_en),
        .step_win   (step_win),
        .clear      (addr_clear),
        .img_rd_addr(img_rd_addr),
        .flt_rd_addr(flt_rd_addr),
        .win_idx    (win_idx),
        .first_tap  (first_tap),
        .last_tap   (last_tap),
        .last_win   (last_win)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            load_cnt  <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            mac_en    <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        load_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        if (load_cnt == LAST_BEAT) begin
                            state    <= COMPUTE;
                            in_ready <= 1'b0;
                            mac_en   <= 1'b1;
                            load_cnt <= '0;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (last_tap) begin
                        state     <= DRAIN;
                        mac_en    <= 1'b0;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_win) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state  <= COMPUTE;
                            mac_en <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CONV_SEQ_PERF_EN
    // Cycle count survives DONE so software can read it before the next start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if ((state == IDLE) && start) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (out_valid && !out_ready) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed self-checking bench for conv_seq_ctrl: a 5/3/1 instance for the
// main scenarios and a 3/3/1 instance for the single-window case.
module tb_conv_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, in_valid, out_ready;
    logic       in_ready, img_wr_en, flt_wr_en, mac_en, mac_clear;
    logic       out_valid, out_last, busy, done;
    logic [4:0] img_wr_addr, img_rd_addr;
    logic [3:0] flt_wr_addr, flt_rd_addr, out_idx;

    logic       start3, in_valid3, out_ready3;
    logic       in_ready3, img_wr_en3, flt_wr_en3, mac_en3, mac_clear3;
    logic       out_valid3, out_last3, busy3, done3;
    logic [3:0] img_wr_addr3, img_rd_addr3, flt_wr_addr3, flt_rd_addr3;
    logic [0:0] out_idx3;

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] perf_cycles, perf_cycles3;
    logic [15:0] perf_stall, perf_stall3;
`endif

    int tests;
    int fails;

    conv_seq_ctrl #(.IFMAP(5), .FILTER(3), .MAC_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .img_wr_en(img_wr_en), .img_wr_addr(img_wr_addr),
        .flt_wr_en(flt_wr_en), .flt_wr_addr(flt_wr_addr),
        .img_rd_addr(img_rd_addr), .flt_rd_addr(flt_rd_addr),
        .mac_en(mac_en), .mac_clear(mac_clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_last(out_last), .busy(busy), .done(done)
`ifdef CONV_SEQ_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    conv_seq_ctrl #(.IFMAP(3), .FILTER(3), .MAC_LAT(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .in_valid(in_valid3), .in_ready(in_ready3),
        .img_wr_en(img_wr_en3), .img_wr_addr(img_wr_addr3),
        .flt_wr_en(flt_wr_en3), .flt_wr_addr(flt_wr_addr3),
        .img_rd_addr(img_rd_addr3), .flt_rd_addr(flt_rd_addr3),
        .mac_en(mac_en3), .mac_clear(mac_clear3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_idx(out_idx3),
        .out_last(out_last3), .busy(busy3), .done(done3)
`ifdef CONV_SEQ_PERF_EN
        , .perf_cycles(perf_cycles3), .perf_stall(perf_stall3)
`endif
    );

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        tests++;
        if ({busy, in_ready, img_wr_en, flt_wr_en, mac_en, mac_clear, out_valid, out_last, done} !== 9'b0) begin
            fails++;
            $display("[TB] FAIL reset_flags: got %b expected 000000000",
                     {busy, in_ready, img_wr_en, flt_wr_en, mac_en, mac_clear, out_valid, out_last, done});
        end
        tests++;
        if ({img_wr_addr, img_rd_addr, flt_wr_addr, flt_rd_addr, out_idx} !== 22'b0) begin
            fails++;
            $display("[TB] FAIL reset_addrs: got %h expected 0",
                     {img_wr_addr, img_rd_addr, flt_wr_addr, flt_rd_addr, out_idx});
        end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL idle_after_reset: busy=%b in_ready=%b expected 0 0", busy, in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_full_job();
        int beats = 0;
        int outs = 0;
        int cyc = 1;
        bit got_done = 1'b0;
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 400 && !got_done; i++) begin
            in_valid = (beats < 25);
            #1;
            if (img_wr_en) begin
                tests++;
                if (img_wr_addr !== 5'(beats) || flt_wr_en !== (beats < 9)) begin
                    fails++;
                    $display("[TB] FAIL load_beat%0d: addr=%0d flt_wr_en=%b expected addr=%0d flt_wr_en=%b",
                             beats, img_wr_addr, flt_wr_en, beats, (beats < 9));
                end
                if (flt_wr_en) begin
                    tests++;
                    if (flt_wr_addr !== 4'(beats)) begin
                        fails++;
                        $display("[TB] FAIL flt_addr: got %0d expected %0d", flt_wr_addr, beats);
                    end
                end
                beats++;
            end
            if (out_valid && out_ready) begin
                tests++;
                if (out_idx !== 4'(outs) || out_last !== (outs == 8)) begin
                    fails++;
                    $display("[TB] FAIL out%0d: idx=%0d last=%b expected idx=%0d last=%b",
                             outs, out_idx, out_last, outs, (outs == 8));
                end
                outs++;
            end
            if (done) begin
                got_done = 1'b1;
                tests++;
                if (cyc != 125) begin
                    fails++;
                    $display("[TB] FAIL done_cycle: got %0d expected 125", cyc);
                end
`ifdef CONV_SEQ_PERF_EN
                tests++;
                if (perf_cycles !== 32'd124 || perf_stall !== 16'd0) begin
                    fails++;
                    $display("[TB] FAIL perf_full: cycles=%0d stall=%0d expected 124 0", perf_cycles, perf_stall);
                end
`endif
                start = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0;
        tests++;
        if (!got_done || beats != 25 || outs != 9) begin
            fails++;
            $display("[TB] FAIL full_job_totals: done=%b beats=%0d outs=%0d expected 1 25 9", got_done, beats, outs);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL after_done: done=%b busy=%b in_ready=%b expected 0 0 0", done, busy, in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_window();
        int exp_img[9] = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
        int beats = 0;
        int win = 0;
        int tap = 0;
        bit got_done = 1'b0;
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 400 && !got_done; i++) begin
            in_valid = (beats < 25);
            #1;
            if (img_wr_en) beats++;
            if (mac_en && win == 5) begin
                tests++;
                if (tap >= 9) begin
                    fails++;
                    $display("[TB] FAIL win5_extra_tap: got tap %0d expected at most 8", tap);
                end else if (img_rd_addr !== 5'(exp_img[tap]) || flt_rd_addr !== 4'(tap) || mac_clear !== (tap == 0)) begin
                    fails++;
                    $display("[TB] FAIL win5_tap%0d: img=%0d flt=%0d clr=%b expected img=%0d flt=%0d clr=%b",
                             tap, img_rd_addr, flt_rd_addr, mac_clear, exp_img[tap], tap, (tap == 0));
                end
                tap++;
            end
            if (out_valid && out_ready) win++;
            if (done) got_done = 1'b1;
            else @(negedge clk);
        end
        in_valid = 1'b0;
        tests++;
        if (tap != 9 || !got_done) begin
            fails++;
            $display("[TB] FAIL win5_taps: got %0d taps done=%b expected 9 taps done=1", tap, got_done);
        end
        @(negedge clk);
    endtask

    task automatic test_load_toggle();
        int beats = 0;
        bit got_done = 1'b0;
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 400 && !got_done; i++) begin
            in_valid = (beats < 25) ? (i % 2 == 0) : (i % 3 == 0);
            #1;
            if (!in_valid) begin
                tests++;
                if (img_wr_en !== 1'b0 || flt_wr_en !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL write_without_valid: img=%b flt=%b expected 0 0", img_wr_en, flt_wr_en);
                end
            end
            if (img_wr_en) begin
                tests++;
                if (beats >= 25 || img_wr_addr !== 5'(beats)) begin
                    fails++;
                    $display("[TB] FAIL toggle_write: addr=%0d after %0d beats expected addr=%0d within 25",
                             img_wr_addr, beats, beats);
                end
                beats++;
            end
            if (done) got_done = 1'b1;
            else @(negedge clk);
        end
        in_valid = 1'b0;
        tests++;
        if (beats != 25 || !got_done) begin
            fails++;
            $display("[TB] FAIL toggle_totals: beats=%0d done=%b expected 25 1", beats, got_done);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        int beats = 0;
        int outs = 0;
        int stalled = 0;
        int cyc = 1;
        bit got_done = 1'b0;
        pulse_start();
        for (int i = 0; i < 400 && !got_done; i++) begin
            in_valid = (beats < 25);
            if (out_valid && out_idx == 4'd3 && stalled < 4) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (!out_ready) begin
                tests++;
                if (out_valid !== 1'b1 || out_idx !== 4'd3 || mac_en !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL stall_hold%0d: valid=%b idx=%0d mac_en=%b expected 1 3 0",
                             stalled, out_valid, out_idx, mac_en);
                end
            end
            if (img_wr_en) beats++;
            if (out_valid && out_ready) begin
                tests++;
                if (out_idx !== 4'(outs)) begin
                    fails++;
                    $display("[TB] FAIL stall_out_idx: got %0d expected %0d", out_idx, outs);
                end
                outs++;
            end
            if (done) begin
                got_done = 1'b1;
                tests++;
                if (cyc != 129) begin
                    fails++;
                    $display("[TB] FAIL stall_done_cycle: got %0d expected 129", cyc);
                end
`ifdef CONV_SEQ_PERF_EN
                tests++;
                if (perf_stall !== 16'd4) begin
                    fails++;
                    $display("[TB] FAIL perf_stall: got %0d expected 4", perf_stall);
                end
`endif
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (stalled != 4 || outs != 9 || !got_done) begin
            fails++;
            $display("[TB] FAIL stall_totals: stalled=%0d outs=%0d done=%b expected 4 9 1", stalled, outs, got_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        int cyc = 1;
        bit got_done = 1'b0;
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 60 && beats < 25; i++) begin
            in_valid = 1'b1;
            start = (beats == 10);
            #1;
            if (img_wr_en) begin
                tests++;
                if (img_wr_addr !== 5'(beats)) begin
                    fails++;
                    $display("[TB] FAIL busy_start_addr: got %0d expected %0d", img_wr_addr, beats);
                end
                beats++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (mac_en !== 1'b1 || img_rd_addr !== 5'd5 || flt_rd_addr !== 4'd3) begin
            fails++;
            $display("[TB] FAIL mid_compute: mac_en=%b img=%0d flt=%0d expected 1 5 3", mac_en, img_rd_addr, flt_rd_addr);
        end
        rst = 1'b0;
        #1;
        tests++;
        if ({busy, in_ready, mac_en, mac_clear, out_valid, done, img_rd_addr, flt_rd_addr} !== 15'b0) begin
            fails++;
            $display("[TB] FAIL async_reset: got %b expected all 0",
                     {busy, in_ready, mac_en, mac_clear, out_valid, done, img_rd_addr, flt_rd_addr});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        beats = 0;
        pulse_start();
        for (int i = 0; i < 400 && !got_done; i++) begin
            in_valid = (beats < 25);
            #1;
            if (img_wr_en) begin
                if (beats == 0) begin
                    tests++;
                    if (img_wr_addr !== 5'd0) begin
                        fails++;
                        $display("[TB] FAIL restart_first_addr: got %0d expected 0", img_wr_addr);
                    end
                end
                beats++;
            end
            if (done) begin
                got_done = 1'b1;
                tests++;
                if (cyc != 125) begin
                    fails++;
                    $display("[TB] FAIL restart_done_cycle: got %0d expected 125", cyc);
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0;
        tests++;
        if (beats != 25 || !got_done) begin
            fails++;
            $display("[TB] FAIL restart_totals: beats=%0d done=%b expected 25 1", beats, got_done);
        end
        @(negedge clk);
    endtask

    task automatic test_small();
        int beats = 0;
        int outs = 0;
        int cyc = 1;
        bit got_done = 1'b0;
        out_ready3 = 1'b1;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int i = 0; i < 100 && !got_done; i++) begin
            in_valid3 = (beats < 9);
            #1;
            if (img_wr_en3) beats++;
            if (out_valid3) begin
                tests++;
                if (out_idx3 !== 1'b0 || out_last3 !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL small_out: idx=%0d last=%b expected 0 1", out_idx3, out_last3);
                end
                outs++;
            end
            if (done3) begin
                got_done = 1'b1;
                tests++;
                if (cyc != 21) begin
                    fails++;
                    $display("[TB] FAIL small_done_cycle: got %0d expected 21", cyc);
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        in_valid3 = 1'b0;
        tests++;
        if (outs != 1 || beats != 9 || !got_done) begin
            fails++;
            $display("[TB] FAIL small_totals: outs=%0d beats=%0d done=%b expected 1 9 1", outs, beats, got_done);
        end
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        start3 = 1'b0;
        in_valid3 = 1'b0;
        out_ready3 = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_job();
        test_window();
        test_load_toggle();
        test_stall();
        test_reset_mid();
        test_small();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
